// File: rtl/serial_add_nbit_if.sv
// serial_add_nbit_if: start/busy/done handshake and operand/result bus of the bit-serial adder
// master drives start, a, b, ci and observes busy, done, sum, co (and ovf when OVF_FLAG_EN is defined)
// slave is the adder side
interface serial_add_nbit_if #(parameter int n = 4);
  logic start, ci, busy, done, co;
  logic [n-1:0] a, b, sum;
`ifdef OVF_FLAG_EN
  logic ovf;
`endif
  modport master(output start, a, b, ci, input busy, done, sum, co
`ifdef OVF_FLAG_EN
    , ovf
`endif
  );
  modport slave(input start, a, b, ci, output busy, done, sum, co
`ifdef OVF_FLAG_EN
    , ovf
`endif
  );
endinterface

// File: rtl/serial_add_nbit.sv
// serial_add_nbit: bit-serial n-bit adder, LSB first, one bit per clock under start/busy/done
// ports: clk, rst_n (sync active-low), io (slave): start, a, b, ci in; busy, done, sum, co out
// optional macro OVF_FLAG_EN adds the registered signed-overflow output io.ovf
module serial_add_nbit #(parameter int n = 4) (
  input logic clk,
  input logic rst_n,
  serial_add_nbit_if.slave io
);
  localparam int iw = $clog2(n) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [n-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
  logic [iw-1:0] idx_q, idx_d;
  logic c_q, c_d, co_q, co_d, s, cn, last;
`ifdef OVF_FLAG_EN
  logic ovf_q, ovf_d;
`endif
  assign s = a_q[0] ^ b_q[0] ^ c_q;
  assign cn = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  assign last = idx_q == iw'(n - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    r_d = r_q;
    idx_d = idx_q;
    sum_d = sum_q;
    co_d = co_q;
`ifdef OVF_FLAG_EN
    ovf_d = ovf_q;
`endif
    if (state_q == IDLE && io.start) begin
      state_d = RUN;
      a_d = io.a;
      b_d = io.b;
      c_d = io.ci;
      r_d = '0;
      idx_d = '0;
    end else if (state_q == RUN) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      c_d = cn;
      r_d = {s, r_q[n-1:1]};
      idx_d = idx_q + 1'b1;
      if (last) begin
        state_d = DONE;
        sum_d = {s, r_q[n-1:1]};
        co_d = cn;
`ifdef OVF_FLAG_EN
        // operands have been shifted down, so bit 0 now holds the original sign bits
        ovf_d = (a_q[0] == b_q[0]) && (s != a_q[0]);
`endif
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      r_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
      co_q <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      r_q <= r_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      co_q <= co_d;
`ifdef OVF_FLAG_EN
      ovf_q <= ovf_d;
`endif
    end
  end
  assign io.busy = state_q == RUN;
  assign io.done = state_q == DONE;
  assign io.sum = sum_q;
  assign io.co = co_q;
`ifdef OVF_FLAG_EN
  assign io.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_nbit.sv
// tb_serial_add_nbit: table, hand-written corner sequences and random ops against an arithmetic model
module tb_serial_add_nbit;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  serial_add_nbit_if #(.n(N)) io();
  serial_add_nbit #(.n(N)) dut(.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic ci;
    logic [N-1:0] s;
    logic co;
    logic ovf;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [N:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
    int t;
    t = int'(a) + int'(b) + int'(ci);
    return (N+1)'(t);
  endfunction
  function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
    int t;
    t = int'($signed(a)) + int'($signed(b)) + int'(ci);
    return t > (2 ** (N - 1)) - 1 || t < -(2 ** (N - 1));
  endfunction
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                       input logic [N-1:0] es, input logic eco, input logic eovf, input string nm);
    int cyc = 0;
    int bc = 0;
    @(negedge clk);
    io.a = a;
    io.b = b;
    io.ci = ci;
    io.start = 1'b1;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    io.a = N'($urandom);
    io.b = N'($urandom);
    io.ci = 1'($urandom);
    while (cyc <= 20) begin
      @(negedge clk);
      if (io.done) break;
      bc += int'(io.busy);
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(N));
    chk({nm, " busy_cycles"}, 32'(bc), 32'(N));
    chk({nm, " busy_at_done"}, 32'(io.busy), 32'(0));
    chk({nm, " sum"}, 32'(io.sum), 32'(es));
    chk({nm, " co"}, 32'(io.co), 32'(eco));
`ifdef OVF_FLAG_EN
    chk({nm, " ovf"}, 32'(io.ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("unexpected x in model");
`endif
    @(negedge clk);
    chk({nm, " done_one_cycle"}, 32'(io.done), 32'(0));
  endtask
  initial begin
    int d1, d2, dc;
    logic [N-1:0] s1, s2;
    logic [N:0] r;
    logic [N-1:0] ra, rb;
    logic rc;
    io.start = 1'b0;
    io.a = '0;
    io.b = '0;
    io.ci = 1'b0;
    tbl[0] = '{4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0};
    tbl[1] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[2] = '{4'b1001, 4'b0110, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[3] = '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1};
    tbl[4] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
    tbl[5] = '{4'b0101, 4'b1011, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[6] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(io.busy), 32'(0));
    chk("reset done", 32'(io.done), 32'(0));
    chk("reset sum", 32'(io.sum), 32'(0));
    chk("reset co", 32'(io.co), 32'(0));
`ifdef OVF_FLAG_EN
    chk("reset ovf", 32'(io.ovf), 32'(0));
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].co, tbl[i].ovf, $sformatf("tbl%0d", i));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold sum", 32'(io.sum), 32'hf);
      chk("hold co", 32'(io.co), 32'(1));
      chk("hold done", 32'(io.done), 32'(0));
    end
    d1 = -1;
    d2 = -1;
    s1 = '0;
    s2 = '0;
    @(negedge clk);
    io.a = 4'd3;
    io.b = 4'd4;
    io.ci = 1'b0;
    io.start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 2) begin
        io.a = 4'd9;
        io.b = 4'd5;
      end
      if (io.done) begin
        if (d1 < 0) begin
          d1 = i;
          s1 = io.sum;
        end else if (d2 < 0) begin
          d2 = i;
          s2 = io.sum;
        end
      end
    end
    io.start = 1'b0;
    chk("held start first done", 32'(d1), 32'(N + 1));
    chk("held start period", 32'(d2 - d1), 32'(N + 2));
    chk("held start sum1", 32'(s1), 32'd7);
    chk("held start sum2", 32'(s2), 32'd14);
    repeat (N + 4) @(negedge clk);
    io.a = 4'd5;
    io.b = 4'd6;
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(io.busy), 32'(0));
    chk("abort done", 32'(io.done), 32'(0));
    chk("abort sum", 32'(io.sum), 32'(0));
    chk("abort co", 32'(io.co), 32'(0));
    rst_n = 1'b1;
    dc = 0;
    repeat (8) begin
      @(negedge clk);
      dc += int'(io.done);
    end
    chk("abort no done", 32'(dc), 32'(0));
    do_op(4'b0110, 4'b0111, 1'b1, 4'b1110, 1'b0, 1'b1, "after abort");
    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom);
      r = ref_sum(ra, rb, rc);
      do_op(ra, rb, rc, r[N-1:0], r[N], ref_ovf(ra, rb, rc), $sformatf("rnd%0d", i));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
